// File: rtl/bcd_nibble_alu_seq_if.sv
// Request/response bundle for the nibble-serial ADC/SBC sequencer.
interface bcd_nibble_alu_seq_if #(parameter int MAX_W = 16);
  logic             EN;
  logic             START;
  logic [MAX_W-1:0] A;
  logic [MAX_W-1:0] B;
  logic             CI;
  logic             ADD;
  logic             BCD;
  logic             W16;
  logic             BUSY;
  logic             DONE;
  logic [MAX_W-1:0] RES;
  logic             CO;
  logic             VO;
  logic             ZO;
  logic             NO;

  modport master (output EN, START, A, B, CI, ADD, BCD, W16,
                  input  BUSY, DONE, RES, CO, VO, ZO, NO);
  modport slave  (input  EN, START, A, B, CI, ADD, BCD, W16,
                  output BUSY, DONE, RES, CO, VO, ZO, NO);
endinterface

// File: rtl/bcd_nibble_alu_seq.sv
// 65C816 ADC/SBC sequencer: one 4-bit adder slice walks the operands LSB nibble
// first, rippling carry and applying decimal correction per nibble.
module bcd_nibble_alu_seq #(
  parameter int MAX_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  bcd_nibble_alu_seq_if.slave  bus
);
  localparam int NIB = MAX_W / 4;
  localparam int IW  = $clog2(NIB + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    last_idx;
  logic             carry;
  logic             add_q, bcd_q, w16_q;
  logic [MAX_W-1:0] a_q, b_q, res_q;
  logic             co_q, vo_q, zo_q, no_q;

  logic [MAX_W-1:0] a_sh, b_sh, res_nxt;
  logic [3:0]       a_n, b_n, b2, sum;
  logic [4:0]       bin;
  logic             cout;
  logic             accept;

  assign last_idx = w16_q ? IW'(NIB - 1) : IW'(1);
  assign accept   = bus.START && (state != S_RUN);

  // Single nibble slice; idx == last_idx+1 is the flag-settle cycle and reads zeros.
  always_comb begin
    a_sh = a_q >> (4 * idx);
    b_sh = b_q >> (4 * idx);
    a_n  = a_sh[3:0];
    b_n  = b_sh[3:0];
    b2   = add_q ? b_n : ~b_n;
    bin  = {1'b0, a_n} + {1'b0, b2} + {4'b0, carry};
    sum  = bin[3:0];
    cout = bin[4];
    if (bcd_q && add_q && (bin > 5'd9)) begin
      sum  = bin[3:0] + 4'd6;
      cout = 1'b1;
    end else if (bcd_q && !add_q && !bin[4]) begin
      sum  = bin[3:0] - 4'd6;
      cout = 1'b0;
    end
    res_nxt = (res_q & ~(MAX_W'(4'hF) << (4 * idx))) | (MAX_W'(sum) << (4 * idx));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      add_q <= 1'b0;
      bcd_q <= 1'b0;
      w16_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      co_q  <= 1'b0;
      vo_q  <= 1'b0;
      zo_q  <= 1'b0;
      no_q  <= 1'b0;
    end else if (bus.EN) begin
      case (state)
        S_RUN: begin
          if (idx == last_idx + IW'(1)) begin
            state <= S_DONE;
          end else begin
            res_q <= res_nxt;
            carry <= cout;
            idx   <= idx + IW'(1);
            if (idx == last_idx) begin
              co_q <= cout;
              vo_q <= ~(a_n[3] ^ b2[3]) & (a_n[3] ^ bin[3]);
              zo_q <= w16_q ? (res_nxt == '0) : (res_nxt[7:0] == 8'h00);
              no_q <= w16_q ? res_nxt[MAX_W-1] : res_nxt[7];
            end
          end
        end
        default: begin
          if (accept) begin
            state <= S_RUN;
            idx   <= '0;
            carry <= bus.CI;
            a_q   <= bus.A;
            b_q   <= bus.B;
            add_q <= bus.ADD;
            bcd_q <= bus.BCD;
            w16_q <= bus.W16;
            // 8-bit ops pass the hidden high accumulator byte through untouched
            if (!bus.W16) res_q[MAX_W-1:8] <= bus.A[MAX_W-1:8];
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.BUSY = (state == S_RUN);
  assign bus.DONE = (state == S_DONE);
  assign bus.RES  = res_q;
  assign bus.CO   = co_q;
  assign bus.VO   = vo_q;
  assign bus.ZO   = zo_q;
  assign bus.NO   = no_q;
endmodule

// File: tb/tb_bcd_nibble_alu_seq.sv
// Randomized bench for bcd_nibble_alu_seq against a whole-word decimal/binary model.
module tb_bcd_nibble_alu_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_nibble_alu_seq_if #(.MAX_W(16)) bus ();
  bcd_nibble_alu_seq #(.MAX_W(16)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus.slave));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v, input int nd);
    int r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'((v >> (4 * i)) & 16'hF);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v, input int nd);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < nd; i++) begin
      r = r | (16'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  // Whole-operand reference: decimal ops use integer decimal arithmetic, V from the top digit.
  task automatic ref_model(input logic [15:0] a, input logic [15:0] b, input logic ci,
                           input logic add, input logic bcd, input logic w16,
                           output logic [15:0] res, output logic co, output logic vo,
                           output logic zo, output logic no);
    int nd = w16 ? 4 : 2;
    int w  = nd * 4;
    logic [15:0] mask = w16 ? 16'hFFFF : 16'h00FF;
    logic [15:0] b2   = (add ? b : ~b) & mask;
    logic [15:0] lo;
    logic [16:0] full;
    logic [3:0]  at, bt;
    logic [4:0]  bs;
    int p, pl, da, db, s, cin_t;
    if (!bcd) begin
      full = {1'b0, a & mask} + {1'b0, b2} + {16'b0, ci};
      lo   = full[15:0] & mask;
      co   = full[w];
      vo   = ~(a[w-1] ^ b2[w-1]) & (a[w-1] ^ lo[w-1]);
    end else begin
      p  = w16 ? 10000 : 100;
      pl = p / 10;
      da = bcd2int(a, nd);
      db = bcd2int(b, nd);
      if (add) begin
        s     = da + db + int'(ci);
        co    = (s >= p);
        lo    = int2bcd(s % p, nd);
        cin_t = ((da % pl) + (db % pl) + int'(ci)) >= pl ? 1 : 0;
      end else begin
        s     = da - db - (1 - int'(ci));
        co    = (s >= 0);
        lo    = int2bcd((s + p) % p, nd);
        cin_t = ((da % pl) - (db % pl) - (1 - int'(ci))) >= 0 ? 1 : 0;
      end
      at = 4'(a >> (w - 4));
      bt = 4'(b2 >> (w - 4));
      bs = {1'b0, at} + {1'b0, bt} + 5'(cin_t);
      vo = ~(at[3] ^ bt[3]) & (at[3] ^ bs[3]);
    end
    res = w16 ? lo : {a[15:8], lo[7:0]};
    zo  = (lo == 16'h0);
    no  = lo[w-1];
  endtask

  task automatic do_op(input string t, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic add, input logic bcd, input logic w16,
                       input int stall_len, input bit poke);
    logic [15:0] er;
    logic ec, ev, ez, eno;
    int n, cyc, edges;
    ref_model(a, b, ci, add, bcd, w16, er, ec, ev, ez, eno);
    n = w16 ? 4 : 2;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.CI = ci; bus.ADD = add; bus.BCD = bcd; bus.W16 = w16;
    bus.EN = 1'b1; bus.START = 1'b1;
    @(posedge clk); #1;
    bus.START = 1'b0;
    bus.A = 16'($urandom); bus.B = 16'($urandom); bus.CI = 1'($urandom);
    bus.ADD = 1'($urandom); bus.BCD = 1'($urandom); bus.W16 = 1'($urandom);
    chk({t, "_busy_acc"}, 32'(bus.BUSY), 32'd1);
    cyc = 0; edges = 0;
    while (!bus.DONE && cyc < 60) begin
      @(negedge clk);
      bus.EN    = !(stall_len > 0 && cyc >= 2 && cyc < 2 + stall_len);
      bus.START = poke && (cyc == 1);
      @(posedge clk); #1;
      if (bus.EN) edges++;
      cyc++;
      bus.START = 1'b0;
      if (cyc < n + 1 + stall_len) chk({t, "_busy_run"}, 32'(bus.BUSY), 32'd1);
    end
    bus.EN = 1'b1;
    chk({t, "_done"}, 32'(bus.DONE), 32'd1);
    chk({t, "_lat_en"}, 32'(edges), 32'(n + 1));
    chk({t, "_lat_cyc"}, 32'(cyc), 32'(n + 1 + stall_len));
    chk({t, "_busy_done"}, 32'(bus.BUSY), 32'd0);
    chk({t, "_res"}, 32'(bus.RES), 32'(er));
    chk({t, "_flags"}, 32'({bus.CO, bus.VO, bus.ZO, bus.NO}), 32'({ec, ev, ez, eno}));
    // DONE must persist through a disabled cycle and drop on the next enabled edge
    @(negedge clk); bus.EN = 1'b0;
    @(posedge clk); #1;
    chk({t, "_done_hold"}, 32'(bus.DONE), 32'd1);
    @(negedge clk); bus.EN = 1'b1;
    @(posedge clk); #1;
    chk({t, "_done_drop"}, 32'({bus.DONE, bus.BUSY}), 32'd0);
    chk({t, "_res_hold"}, 32'(bus.RES), 32'(er));
  endtask

  function automatic logic [15:0] rand_bcd(input int nd);
    return int2bcd(int'($urandom_range(0, (nd == 4) ? 9999 : 99)), nd);
  endfunction

  initial begin
    logic [15:0] ra, rb, tmp;
    logic rw, rbcd;
    rst_n = 1'b0;
    bus.EN = 1'b0; bus.START = 1'b0; bus.A = '0; bus.B = '0;
    bus.CI = 1'b0; bus.ADD = 1'b1; bus.BCD = 1'b0; bus.W16 = 1'b0;
    #12;
    chk("reset_out", 32'({bus.BUSY, bus.DONE, bus.CO, bus.VO, bus.ZO, bus.NO}), 32'd0);
    chk("reset_res", 32'(bus.RES), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op("t1", 16'h0999, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    chk("t1_lit", 32'({bus.RES, bus.CO, bus.ZO, bus.NO}), 32'({16'h1000, 3'b000}));
    do_op("t2", 16'h1299, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    chk("t2_lit", 32'({bus.RES, bus.CO, bus.ZO}), 32'({16'h1200, 2'b11}));
    do_op("t3", 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    chk("t3_lit", 32'({bus.RES, bus.CO, bus.NO, bus.ZO}), 32'({16'h0099, 3'b010}));
    do_op("t4a", 16'h007F, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("t4a_lit", 32'({bus.RES, bus.VO, bus.NO, bus.CO}), 32'({16'h0080, 3'b110}));
    do_op("t4b", 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    chk("t4b_lit", 32'({bus.RES, bus.VO, bus.CO}), 32'({16'h7FFF, 2'b11}));
    do_op("t5", 16'h0999, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 3, 1'b1);
    chk("t5_lit", 32'(bus.RES), 32'h1000);

    // asynchronous reset in the middle of a 16-bit operation
    @(negedge clk);
    bus.A = 16'h0999; bus.B = 16'h0001; bus.CI = 1'b0; bus.ADD = 1'b1;
    bus.BCD = 1'b1; bus.W16 = 1'b1; bus.EN = 1'b1; bus.START = 1'b1;
    @(posedge clk); #1; bus.START = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("t6_busy_pre", 32'(bus.BUSY), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out", 32'({bus.BUSY, bus.DONE, bus.CO, bus.VO, bus.ZO, bus.NO}), 32'd0);
    chk("t6_rst_res", 32'(bus.RES), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    do_op("t6", 16'h007F, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("t6_lit", 32'({bus.RES, bus.VO, bus.NO}), 32'({16'h0080, 2'b11}));

    for (int i = 0; i < 40; i++) begin
      rw   = 1'($urandom);
      rbcd = 1'($urandom);
      if (rbcd) begin
        ra = rand_bcd(rw ? 4 : 2);
        rb = rand_bcd(rw ? 4 : 2);
        if (!rw) begin
          tmp = 16'($urandom);
          ra[15:8] = tmp[15:8];
          rb[15:8] = tmp[7:0];
        end
      end else begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end
      do_op($sformatf("rnd%0d", i), ra, rb, 1'($urandom), 1'($urandom), rbcd, rw,
            (i % 5 == 0) ? int'($urandom_range(1, 3)) : 0, 1'(i % 3 == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
